// File: rtl/sound_tone_gen.sv
// Note-table square-wave tone generator with a linear-fade sample path for the DAC.
// Optional eat-effect warble is built only when SOUND_TONE_GEN_EAT_WARBLE_EN is defined.
module sound_tone_gen #(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int AMP_MAX       = 16384,
    parameter int AMP_STEP      = 1024,
    parameter int RELEASE_TICK  = 1000,
    parameter int WARBLE_CYCLES = 2_500_000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        Enable_Sound,
    input  logic [3:0]  frequency,
    input  logic        Enable_Eat,
    output logic        audio_out,
    output logic [15:0] sample,
    output logic        active
);

    localparam int REL_W = (RELEASE_TICK > 1) ? $clog2(RELEASE_TICK) : 1;
    localparam logic [15:0]      AMP_MAX_V  = 16'(AMP_MAX);
    localparam logic [15:0]      AMP_STEP_V = 16'(AMP_STEP);
    localparam logic [REL_W-1:0] REL_LAST   = REL_W'(RELEASE_TICK - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             phase_reg, phase_next;
    logic [19:0]      hp_cnt_reg, hp_cnt_next;
    logic [15:0]      amp_reg, amp_next;
    logic [3:0]       code_q_reg, code_q_next;
    logic [REL_W-1:0] rel_cnt_reg, rel_cnt_next;
    logic [3:0]       eff_code;
    logic [19:0]      hp_table [16];

    function automatic int note_freq(input int c);
        case (c)
            0:       return 523;
            1:       return 554;
            2:       return 587;
            3:       return 622;
            4:       return 659;
            5:       return 698;
            6:       return 740;
            7:       return 784;
            8:       return 831;
            9:       return 880;
            10:      return 932;
            11:      return 988;
            12:      return 1047;
            13:      return 1175;
            14:      return 1319;
            default: return 1568;
        endcase
    endfunction

    // Half-period table is pure elaboration-time constants.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_hp
            assign hp_table[gi] = 20'(CLK_FREQ_HZ / (2 * note_freq(gi)));
        end
    endgenerate

`ifdef SOUND_TONE_GEN_EAT_WARBLE_EN
    localparam int WRB_W = (WARBLE_CYCLES > 1) ? $clog2(WARBLE_CYCLES) : 1;
    localparam logic [WRB_W-1:0] WRB_LAST = WRB_W'(WARBLE_CYCLES - 1);

    logic [WRB_W-1:0] wrb_cnt_reg, wrb_cnt_next;
    logic             warble_sel_reg, warble_sel_next;

    always_comb begin
        wrb_cnt_next    = '0;
        warble_sel_next = 1'b0;
        if (state_reg == PLAY && Enable_Eat) begin
            if (wrb_cnt_reg == WRB_LAST) begin
                wrb_cnt_next    = '0;
                warble_sel_next = ~warble_sel_reg;
            end else begin
                wrb_cnt_next    = wrb_cnt_reg + WRB_W'(1);
                warble_sel_next = warble_sel_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            wrb_cnt_reg    <= '0;
            warble_sel_reg <= 1'b0;
        end else begin
            wrb_cnt_reg    <= wrb_cnt_next;
            warble_sel_reg <= warble_sel_next;
        end
    end

    assign eff_code = !warble_sel_reg      ? frequency :
                      (frequency > 4'd13)  ? 4'd15     : frequency + 4'd2;
`else
    logic unused_eat;
    assign unused_eat = Enable_Eat;
    assign eff_code   = frequency;
`endif

    // code_q is kept as observable state of the note currently sounding.
    logic unused_code;
    assign unused_code = ^code_q_reg;

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        hp_cnt_next  = hp_cnt_reg;
        amp_next     = amp_reg;
        code_q_next  = code_q_reg;
        rel_cnt_next = rel_cnt_reg;

        // Note changes land only on a half-period boundary, so no short pulses.
        if (state_reg != IDLE) begin
            if (hp_cnt_reg == 20'd0) begin
                phase_next  = ~phase_reg;
                code_q_next = frequency;
                hp_cnt_next = hp_table[eff_code] - 20'd1;
            end else begin
                hp_cnt_next = hp_cnt_reg - 20'd1;
            end
        end

        case (state_reg)
            IDLE: begin
                if (Enable_Sound) begin
                    state_next   = PLAY;
                    code_q_next  = frequency;
                    hp_cnt_next  = hp_table[frequency] - 20'd1;
                    phase_next   = 1'b1;
                    amp_next     = AMP_MAX_V;
                    rel_cnt_next = '0;
                end
            end
            PLAY: begin
                if (!Enable_Sound) begin
                    state_next   = RELEASE;
                    rel_cnt_next = '0;
                end
            end
            RELEASE: begin
                if (Enable_Sound) begin
                    state_next   = PLAY;
                    amp_next     = AMP_MAX_V;
                    rel_cnt_next = '0;
                end else if (amp_reg == 16'd0) begin
                    state_next   = IDLE;
                    phase_next   = 1'b0;
                    hp_cnt_next  = 20'd0;
                    rel_cnt_next = '0;
                end else if (rel_cnt_reg == REL_LAST) begin
                    rel_cnt_next = '0;
                    amp_next     = (amp_reg > AMP_STEP_V) ? amp_reg - AMP_STEP_V : 16'd0;
                end else begin
                    rel_cnt_next = rel_cnt_reg + REL_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            state_reg   <= IDLE;
            phase_reg   <= 1'b0;
            hp_cnt_reg  <= 20'd0;
            amp_reg     <= 16'd0;
            code_q_reg  <= 4'd0;
            rel_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            hp_cnt_reg  <= hp_cnt_next;
            amp_reg     <= amp_next;
            code_q_reg  <= code_q_next;
            rel_cnt_reg <= rel_cnt_next;
        end
    end

    assign active    = (state_reg != IDLE);
    assign audio_out = (state_reg == PLAY) && phase_reg;
    assign sample    = (state_reg == IDLE) ? 16'd0 :
                       phase_reg           ? amp_reg : (~amp_reg + 16'd1);

endmodule

// File: tb/tb_sound_tone_gen.sv
// Scoreboard bench for sound_tone_gen: half-period timing, note change, fade-out, re-attack, reset.
module tb_sound_tone_gen;

    localparam int TB_CLK = 5_000_000;
    localparam int AMP    = 16384;
    localparam int STEP   = 1024;
    localparam int TICK   = 1000;
    localparam int WRB    = 3000;
    localparam int FREQS [16] = '{523, 554, 587, 622, 659, 698, 740, 784,
                                  831, 880, 932, 988, 1047, 1175, 1319, 1568};

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        Enable_Sound = 1'b0;
    logic [3:0]  frequency = 4'd0;
    logic        Enable_Eat = 1'b0;
    logic        audio_out;
    logic [15:0] sample;
    logic        active;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int t;
        int amp;
    } step_t;

    int    hp_q[$];
    step_t amp_q[$];

    sound_tone_gen #(
        .CLK_FREQ_HZ  (TB_CLK),
        .AMP_MAX      (AMP),
        .AMP_STEP     (STEP),
        .RELEASE_TICK (TICK),
        .WARBLE_CYCLES(WRB)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .Enable_Sound(Enable_Sound),
        .frequency   (frequency),
        .Enable_Eat  (Enable_Eat),
        .audio_out   (audio_out),
        .sample      (sample),
        .active      (active)
    );

    always #5 clk = ~clk;

    function automatic int hp_of(input int c);
        return TB_CLK / (2 * FREQS[c]);
    endfunction

    function automatic int mag(input logic [15:0] s);
        logic [15:0] m;
        m = s[15] ? (~s + 16'd1) : s;
        return int'(m);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles until audio_out changes, bounded.
    task automatic measure_half(output int n);
        logic prev;
        prev = audio_out;
        n = 0;
        while (n < 10000) begin
            tick();
            n++;
            if (audio_out !== prev) break;
        end
    endtask

    task automatic drain_hp(input string name, input logic [15:0] amp_pos);
        int n;
        int e;
        while (hp_q.size() > 0) begin
            measure_half(n);
            e = hp_q.pop_front();
            $display("%s half-period=%0d audio_out=%0b", name, n, audio_out);
            total++;
            if (n != e) begin
                bad++;
                $display("FAIL %s_period: got %0d cycles expected %0d", name, n, e);
            end
            total++;
            if (sample !== (audio_out ? amp_pos : (~amp_pos + 16'd1))) begin
                bad++;
                $display("FAIL %s_sample: got %h with audio_out=%0b", name, sample, audio_out);
            end
        end
    endtask

    task automatic test_reset();
        Enable_Sound = 1'b1;
        frequency    = 4'b1010;
        resetN       = 1'b1;
        tick();
        tick();
        total++;
        if (active !== 1'b0 || audio_out !== 1'b0 || sample !== 16'd0) begin
            bad++;
            $display("FAIL reset_outputs: got active=%0b audio=%0b sample=%h expected 0/0/0000",
                     active, audio_out, sample);
        end
        resetN       = 1'b0;
        Enable_Sound = 1'b0;
        tick();
        total++;
        if (active !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got active=%0b expected 0", active);
        end
        $display("reset done");
    endtask

    task automatic test_play();
        frequency    = 4'b1010;
        Enable_Sound = 1'b1;
        tick();
        total++;
        if (active !== 1'b1 || audio_out !== 1'b1 || sample !== 16'h4000) begin
            bad++;
            $display("FAIL play_start: got active=%0b audio=%0b sample=%h expected 1/1/4000",
                     active, audio_out, sample);
        end
        repeat (3) hp_q.push_back(hp_of(10));
        drain_hp("play", 16'h4000);
    endtask

    task automatic test_freq_change();
        repeat (1000) tick();
        frequency = 4'b1001;
        hp_q.push_back(hp_of(10) - 1000);
        hp_q.push_back(hp_of(9));
        hp_q.push_back(hp_of(9));
        drain_hp("freq", 16'h4000);
    endtask

    task automatic test_release();
        int    off_t;
        int    prev;
        int    m;
        int    aud_bad;
        step_t e;
        off_t   = 0;
        aud_bad = 0;
        Enable_Sound = 1'b0;
        tick();
        total++;
        if (audio_out !== 1'b0 || active !== 1'b1 || mag(sample) != AMP) begin
            bad++;
            $display("FAIL release_entry: got audio=%0b active=%0b amp=%0d expected 0/1/%0d",
                     audio_out, active, mag(sample), AMP);
        end
        for (int k = 1; k <= AMP / STEP; k++)
            amp_q.push_back('{t: TICK * k, amp: AMP - STEP * k});
        prev = AMP;
        for (int t = 1; t <= 20000; t++) begin
            tick();
            if (active === 1'b0) begin
                off_t = t;
                break;
            end
            if (audio_out !== 1'b0) aud_bad++;
            m = mag(sample);
            if (m != prev) begin
                prev = m;
                total++;
                if (amp_q.size() == 0) begin
                    bad++;
                    $display("FAIL release_step: got unexpected amp=%0d at cycle %0d", m, t);
                end else begin
                    e = amp_q.pop_front();
                    $display("release step amp=%0d cycle=%0d", m, t);
                    if (m != e.amp || t != e.t) begin
                        bad++;
                        $display("FAIL release_step: got amp=%0d at %0d expected amp=%0d at %0d",
                                 m, t, e.amp, e.t);
                    end
                end
            end
        end
        total++;
        if (off_t != TICK * (AMP / STEP) + 1) begin
            bad++;
            $display("FAIL release_idle_time: got %0d expected %0d", off_t, TICK * (AMP / STEP) + 1);
        end
        total++;
        if (amp_q.size() != 0) begin
            bad++;
            $display("FAIL release_missing_steps: got %0d left expected 0", amp_q.size());
        end
        total++;
        if (aud_bad != 0) begin
            bad++;
            $display("FAIL release_audio_low: got %0d high cycles expected 0", aud_bad);
        end
        total++;
        if (sample !== 16'd0 || audio_out !== 1'b0) begin
            bad++;
            $display("FAIL release_idle_out: got sample=%h audio=%0b expected 0000/0", sample, audio_out);
        end
        amp_q.delete();
    endtask

    task automatic test_reattack();
        frequency    = 4'b1001;
        Enable_Sound = 1'b1;
        tick();
        repeat (100) tick();
        Enable_Sound = 1'b0;
        tick();
        repeat (4999) tick();
        total++;
        if (mag(sample) != AMP - 4 * STEP || audio_out !== 1'b0) begin
            bad++;
            $display("FAIL reattack_pre: got amp=%0d audio=%0b expected %0d/0",
                     mag(sample), audio_out, AMP - 4 * STEP);
        end
        Enable_Sound = 1'b1;
        tick();
        $display("reattack amp=%0d active=%0b audio=%0b", mag(sample), active, audio_out);
        total++;
        if (active !== 1'b1 || audio_out !== 1'b0 || sample !== 16'hC000) begin
            bad++;
            $display("FAIL reattack_state: got active=%0b audio=%0b sample=%h expected 1/0/c000",
                     active, audio_out, sample);
        end
        hp_q.push_back(2 * hp_of(9) - 5101);
        hp_q.push_back(hp_of(9));
        drain_hp("reattack", 16'h4000);
    endtask

    task automatic test_reset_mid_play();
        resetN = 1'b1;
        tick();
        total++;
        if (active !== 1'b0 || audio_out !== 1'b0 || sample !== 16'd0) begin
            bad++;
            $display("FAIL midreset_outputs: got active=%0b audio=%0b sample=%h expected 0/0/0000",
                     active, audio_out, sample);
        end
        resetN       = 1'b0;
        Enable_Sound = 1'b0;
        tick();
        total++;
        if (active !== 1'b0) begin
            bad++;
            $display("FAIL midreset_stays_idle: got active=%0b expected 0", active);
        end
        Enable_Sound = 1'b1;
        tick();
        $display("restart after reset active=%0b audio=%0b", active, audio_out);
        total++;
        if (active !== 1'b1 || audio_out !== 1'b1 || sample !== 16'h4000) begin
            bad++;
            $display("FAIL midreset_restart: got active=%0b audio=%0b sample=%h expected 1/1/4000",
                     active, audio_out, sample);
        end
    endtask

    task automatic test_pulse();
        int off_t;
        off_t  = 0;
        resetN = 1'b1;
        tick();
        resetN       = 1'b0;
        Enable_Sound = 1'b1;
        tick();
        Enable_Sound = 1'b0;
        tick();
        total++;
        if (audio_out !== 1'b0 || active !== 1'b1 || mag(sample) != AMP) begin
            bad++;
            $display("FAIL pulse_release: got audio=%0b active=%0b amp=%0d expected 0/1/%0d",
                     audio_out, active, mag(sample), AMP);
        end
        for (int t = 1; t <= 20000; t++) begin
            tick();
            if (active === 1'b0) begin
                off_t = t;
                break;
            end
        end
        $display("pulse release length=%0d", off_t);
        total++;
        if (off_t != TICK * (AMP / STEP) + 1) begin
            bad++;
            $display("FAIL pulse_release_time: got %0d expected %0d", off_t, TICK * (AMP / STEP) + 1);
        end
    endtask

`ifdef SOUND_TONE_GEN_EAT_WARBLE_EN
    task automatic test_warble();
        int n;
        int n10;
        int n12;
        int other;
        n10   = 0;
        n12   = 0;
        other = 0;
        frequency    = 4'b1010;
        Enable_Eat   = 1'b1;
        Enable_Sound = 1'b1;
        tick();
        repeat (8) begin
            measure_half(n);
            $display("warble half-period=%0d", n);
            if (n == hp_of(10)) n10++;
            else if (n == hp_of(12)) n12++;
            else other++;
        end
        total++;
        if (other != 0 || n10 == 0 || n12 == 0) begin
            bad++;
            $display("FAIL warble_mix: got code10=%0d code12=%0d other=%0d expected both nonzero and 0 other",
                     n10, n12, other);
        end
        Enable_Eat   = 1'b0;
        Enable_Sound = 1'b0;
        resetN       = 1'b1;
        tick();
        resetN = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_play();
        test_freq_change();
        test_release();
        test_reattack();
        test_reset_mid_play();
        test_pulse();
`ifdef SOUND_TONE_GEN_EAT_WARBLE_EN
        test_warble();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
